// File: rtl/multi_camera_config.sv
// multi_camera_config: walks a register ROM per masked camera, issuing SCCB writes (ports: clk/rst, start/cam_mask request, rom_addr/rom_data ROM, sccb_* write handshake, busy/done/error/err_cam status)
module multi_camera_config #(
  parameter int CLK_FREQ = 25000000,
  parameter int NUM_CAMS = 2,
  parameter int ROM_AW = 8,
  parameter int DELAY_MS = 10,
  parameter int TIMEOUT_CYC = 65535,
  localparam int CAM_W = NUM_CAMS > 1 ? $clog2(NUM_CAMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_CAMS-1:0] cam_mask,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [15:0]         rom_data,
  output logic                sccb_start,
  output logic [7:0]          sccb_addr,
  output logic [7:0]          sccb_data,
  output logic [CAM_W-1:0]    sccb_cam,
  input  logic                sccb_ready,
  output logic                busy,
  output logic [NUM_CAMS-1:0] done,
  output logic                error,
  output logic [CAM_W-1:0]    err_cam
);
  localparam logic [31:0] DELAY_CYC = 32'(DELAY_MS * (CLK_FREQ / 1000));
  localparam logic [31:0] TMO = 32'(TIMEOUT_CYC);
  typedef enum logic [3:0] {IDLE, SELECT, FETCH, DECODE, SEND, WAIT_ACK, WAIT_RDY, DELAY, FINISH} state_t;
  state_t state_q, state_d;
  logic start_q, busy_q, busy_d, err_q, err_d, go_q, go_d;
  logic [NUM_CAMS-1:0] pend_q, pend_d, done_q, done_d, cur_bit;
  logic [CAM_W-1:0] cur_q, cur_d, cam_q, cam_d, err_cam_q, err_cam_d, sel;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [15:0] word_q, word_d, wr_q, wr_d;
  logic [31:0] cnt_q, cnt_d;
  logic found, last, tmo, adv, fail;
  always_comb begin
    sel = '0;
    for (int i = NUM_CAMS - 1; i >= 0; i--) if (pend_q[i]) sel = CAM_W'(i);
  end
  assign found = |pend_q;
  assign last = addr_q == '1;
  assign tmo = cnt_q >= TMO;
  assign cur_bit = NUM_CAMS'(1) << cur_q;
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    err_d = err_q;
    err_cam_d = err_cam_q;
    pend_d = pend_q;
    done_d = done_q;
    cur_d = cur_q;
    cam_d = cam_q;
    addr_d = addr_q;
    word_d = word_q;
    wr_d = wr_q;
    cnt_d = cnt_q + 32'd1;
    go_d = 1'b0;
    adv = 1'b0;
    fail = 1'b0;
    case (state_q)
      IDLE: if (start && !start_q) begin
        pend_d = cam_mask;
        done_d = '0;
        err_d = 1'b0;
        err_cam_d = '0;
        busy_d = 1'b1;
        state_d = SELECT;
      end
      SELECT: begin
        state_d = found ? FETCH : FINISH;
        cur_d = found ? sel : cur_q;
        addr_d = found ? '0 : addr_q;
        pend_d = pend_q & ~(NUM_CAMS'(1) << sel);
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        word_d = rom_data;
        cnt_d = '0;
        state_d = rom_data == 16'hFFFF ? SELECT : rom_data == 16'hFFF0 ? DELAY : SEND;
        done_d = rom_data == 16'hFFFF ? done_q | cur_bit : done_q;
      end
      SEND: if (sccb_ready) begin
        go_d = 1'b1;
        wr_d = word_q;
        cam_d = cur_q;
        cnt_d = '0;
        state_d = WAIT_ACK;
      end else fail = tmo;
      WAIT_ACK: if (!sccb_ready) begin
        cnt_d = '0;
        state_d = WAIT_RDY;
      end else fail = tmo;
      WAIT_RDY: if (sccb_ready) adv = 1'b1;
      else fail = tmo;
      DELAY: adv = cnt_q == DELAY_CYC - 32'd1;
      FINISH: begin
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // the last ROM entry closes the channel instead of wrapping the address
    if (adv) begin
      state_d = last ? SELECT : FETCH;
      addr_d = last ? addr_q : addr_q + ROM_AW'(1);
      done_d = last ? done_q | cur_bit : done_q;
    end
    if (fail) begin
      err_d = 1'b1;
      err_cam_d = err_q ? err_cam_q : cur_q;
      state_d = SELECT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      err_cam_q <= '0;
      pend_q <= '0;
      done_q <= '0;
      cur_q <= '0;
      cam_q <= '0;
      addr_q <= '0;
      word_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      busy_q <= busy_d;
      err_q <= err_d;
      err_cam_q <= err_cam_d;
      pend_q <= pend_d;
      done_q <= done_d;
      cur_q <= cur_d;
      cam_q <= cam_d;
      addr_q <= addr_d;
      word_q <= word_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      go_q <= go_d;
    end
  end
  assign rom_addr = addr_q;
  assign sccb_start = go_q;
  assign sccb_addr = wr_q[15:8];
  assign sccb_data = wr_q[7:0];
  assign sccb_cam = cam_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
  assign err_cam = err_cam_q;
endmodule

// File: tb/tb_multi_camera_config.sv
// tb_multi_camera_config: table-driven and scoreboard checks of multi_camera_config with a ROM and SCCB ready model
module tb_multi_camera_config;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sccb_ready = 1'b1;
  logic [1:0] cam_mask = 2'b00;
  logic [1:0] rom_addr;
  logic [15:0] rom_data;
  logic sccb_start, sccb_cam, busy, error, err_cam;
  logic [7:0] sccb_addr, sccb_data;
  logic [1:0] done;
  always #5 clk = ~clk;
  multi_camera_config #(
    .CLK_FREQ(1000000), .NUM_CAMS(2), .ROM_AW(2), .DELAY_MS(1), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cam_mask(cam_mask), .rom_addr(rom_addr),
    .rom_data(rom_data), .sccb_start(sccb_start), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_cam(sccb_cam), .sccb_ready(sccb_ready), .busy(busy), .done(done), .error(error),
    .err_cam(err_cam)
  );
  logic [15:0] rom [4];
  always @(posedge clk) rom_data <= rom[rom_addr];
  int bcnt = 0;
  bit stuck = 1'b0;
  always @(negedge clk) begin
    bcnt = sccb_start ? 5 : (bcnt > 0 ? bcnt - 1 : 0);
    sccb_ready = bcnt == 0 && !(stuck && !error);
  end
  int tests = 0, fails = 0, cyc = 0, n_starts = 0, last_start = 0;
  logic [16:0] exp_q [$];
  typedef struct packed {
    logic [1:0] m;
    logic [3:0][15:0] r;
    logic stk;
    logic [1:0] d;
    logic e;
    logic ec;
    logic [1:0] a;
  } vec_t;
  vec_t vt [5];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    logic [16:0] e;
    @(negedge clk);
    cyc++;
    if (sccb_start) begin
      n_starts++;
      last_start = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got write cam=%0d %h/%h, required none", sccb_cam, sccb_addr, sccb_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", {15'b0, sccb_cam, sccb_addr, sccb_data}, {15'b0, e});
      end
    end
  endtask
  function automatic void push_exp(input logic [1:0] m, input bit stk);
    for (int c = 0; c < 2; c++)
      if (m[c] && !(stk && c == 0))
        for (int a = 0; a < 4; a++) begin
          if (rom[a] == 16'hFFFF) break;
          if (rom[a] != 16'hFFF0) exp_q.push_back({c[0], rom[a]});
        end
  endfunction
  task automatic load(input logic [3:0][15:0] r);
    for (int k = 0; k < 4; k++) rom[k] = r[k];
  endtask
  task automatic run(input logic [1:0] m);
    cam_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4000 && busy; i++) tick();
    check("run_end_busy", busy, 0);
  endtask
  initial begin
    int ns0, w, t0, lat;
    vt[0] = '{2'b11, 64'h0000_FFFF_1101_1280, 1'b0, 2'b11, 1'b0, 1'b0, 2'd2};
    vt[1] = '{2'b11, 64'h0000_FFFF_1101_1280, 1'b1, 2'b10, 1'b1, 1'b0, 2'd2};
    vt[2] = '{2'b00, 64'h0000_FFFF_1101_1280, 1'b0, 2'b00, 1'b0, 1'b0, 2'd2};
    vt[3] = '{2'b10, 64'h0000_0000_FFFF_1280, 1'b0, 2'b10, 1'b0, 1'b0, 2'd1};
    vt[4] = '{2'b11, 64'hDEF0_9ABC_5678_1234, 1'b0, 2'b11, 1'b0, 1'b0, 2'd3};
    load(64'h0000_0000_FFFF_1280);
    start = 1'b1;
    cam_mask = 2'b01;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_sccb", {sccb_start, sccb_cam, sccb_addr, sccb_data}, 0);
    push_exp(2'b01, 1'b0);
    rst = 1'b0;
    tick();
    check("start_held_across_rst", busy, 1);
    for (int i = 0; i < 500 && busy; i++) tick();
    check("start_held_done", done, 2'b01);
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      load(vt[i].r);
      stuck = vt[i].stk;
      push_exp(vt[i].m, vt[i].stk);
      run(vt[i].m);
      stuck = 1'b0;
      check("vec_done", done, vt[i].d);
      check("vec_error", error, vt[i].e);
      check("vec_err_cam", err_cam, vt[i].ec);
      check("vec_rom_addr", rom_addr, vt[i].a);
      check("vec_sb_empty", exp_q.size(), 0);
      repeat (10) tick();
    end
    ns0 = n_starts;
    cam_mask = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (busy && w < 10) begin
      w++;
      tick();
    end
    check("mask0_busy_width", w, 2);
    check("mask0_done", done, 0);
    repeat (5) tick();
    check("mask0_no_traffic", n_starts, ns0);
    load(64'h0000_FFFF_1101_1280);
    push_exp(2'b11, 1'b0);
    cam_mask = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 500 && busy; i++) tick();
    check("midstart_busy", busy, 0);
    check("midstart_done", done, 2'b11);
    repeat (20) tick();
    check("midstart_sb_empty", exp_q.size(), 0);
    load(64'h0000_FFFF_1280_FFF0);
    push_exp(2'b01, 1'b0);
    t0 = cyc;
    run(2'b01);
    lat = last_start - t0;
    check("delay_latency_in_range", lat >= 1003 && lat <= 1012, 1);
    check("delay_done", done, 2'b01);
    check("delay_sb_empty", exp_q.size(), 0);
    load(64'h0000_FFFF_1101_1280);
    push_exp(2'b11, 1'b0);
    ns0 = n_starts;
    cam_mask = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && n_starts == ns0; i++) tick();
    check("rst_mid_first_write", n_starts, ns0 + 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rom_addr", rom_addr, 0);
    check("rst_mid_sccb", {sccb_start, sccb_cam, sccb_addr, sccb_data}, 0);
    check("rst_mid_status", {done, error, err_cam}, 0);
    rst = 1'b0;
    exp_q.delete();
    push_exp(2'b11, 1'b0);
    run(2'b11);
    check("rerun_done", done, 2'b11);
    check("rerun_sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
